// File: rtl/divide_issue_ctrl.sv
// -----------------------------------------------------------------------------
// divide_issue_ctrl
//
// Sits between the execute stage and a multi-cycle divider. It accepts one
// divide/modulo request at a time, issues it to the divider, waits for
// completion, and holds the selected quotient or remainder for writeback
// until writeback takes it. A zero divisor is answered locally without
// touching the divider. A flush discards the current operation. If the
// divider is still working on a discarded command, the block waits in DRAIN
// until that command finishes.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_req_valid/out_req_ready   request handshake from execute
//   in_op                    bit0 = signed, bit1 = remainder (else quotient)
//   in_a, in_b, in_dest      dividend, divisor, destination register
//   in_flush                 discard the current operation
//   out_div_*                divider command (enable, sign mode, operands)
//   in_div_quot/rem          divider results
//   in_div_can_accept_cmd    divider idle / accepts a command
//   in_div_data_ready        divider result present
//   out_res_valid/in_res_ready   result handshake to writeback
//   out_res_data/dest/div_by_zero  buffered result
//   out_busy                 any state other than IDLE (pipeline stall)
// -----------------------------------------------------------------------------
module divide_issue_ctrl #(
   parameter int ARGS_WIDTH      = 32,
   parameter int REG_INDEX_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_req_valid,
   output logic                       out_req_ready,
   input  logic [1:0]                 in_op,
   input  logic [ARGS_WIDTH-1:0]      in_a,
   input  logic [ARGS_WIDTH-1:0]      in_b,
   input  logic [REG_INDEX_WIDTH-1:0] in_dest,
   input  logic                       in_flush,
   output logic                       out_div_enable,
   output logic                       out_div_unsgn_or_sgn,
   output logic [ARGS_WIDTH-1:0]      out_div_num,
   output logic [ARGS_WIDTH-1:0]      out_div_denom,
   input  logic [ARGS_WIDTH-1:0]      in_div_quot,
   input  logic [ARGS_WIDTH-1:0]      in_div_rem,
   input  logic                       in_div_can_accept_cmd,
   input  logic                       in_div_data_ready,
   output logic                       out_res_valid,
   input  logic                       in_res_ready,
   output logic [ARGS_WIDTH-1:0]      out_res_data,
   output logic [REG_INDEX_WIDTH-1:0] out_res_dest,
   output logic                       out_res_div_by_zero,
   output logic                       out_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_DRAIN,
      S_RESULT
   } state_e;

   state_e                     state_q;
   logic [1:0]                 op_q;
   logic [ARGS_WIDTH-1:0]      a_q;
   logic [ARGS_WIDTH-1:0]      b_q;
   logic [REG_INDEX_WIDTH-1:0] dest_q;
   logic [ARGS_WIDTH-1:0]      res_data_q;
   logic                       res_dbz_q;

   logic req_fire;
   logic div_done;

   assign req_fire = in_req_valid & ~in_flush;
   // The divider clears both flags when it accepts a command, so the first
   // WAIT_DONE cycle never sees a stale completion.
   assign div_done = in_div_can_accept_cmd & in_div_data_ready;

   // NOTE: every register, datapath included, is reset; the outputs are
   // required to read zero during reset, and non-blocking assignments keep
   // all the updates in this block simultaneous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         dest_q     <= '0;
         res_data_q <= '0;
         res_dbz_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_fire) begin
                  op_q   <= in_op;
                  a_q    <= in_a;
                  b_q    <= in_b;
                  dest_q <= in_dest;
                  if (in_b == '0) begin
                     // A zero divisor is answered locally.
                     // A divide returns all-ones and a remainder returns the dividend.
                     res_data_q <= in_op[1] ? in_a : '1;
                     res_dbz_q  <= 1'b1;
                     state_q    <= S_RESULT;
                  end else begin
                     state_q    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // Enable is high in this state, so can_accept alone marks acceptance.
               // If a flush coincides with acceptance, the divider still owns
               // the command, and its result must be drained.
               if (in_flush) begin
                  state_q <= in_div_can_accept_cmd ? S_DRAIN : S_IDLE;
               end else if (in_div_can_accept_cmd) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (in_flush) begin
                  state_q <= S_DRAIN;
               end else if (div_done) begin
                  res_data_q <= op_q[1] ? in_div_rem : in_div_quot;
                  res_dbz_q  <= 1'b0;
                  state_q    <= S_RESULT;
               end
            end
            S_DRAIN: begin
               if (!in_flush && div_done) begin
                  state_q <= S_IDLE;
               end
            end
            S_RESULT: begin
               if (in_flush || in_res_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Every output is a decode of registered state or a register.
   // No input has a combinational path to any output.
   assign out_req_ready        = (state_q == S_IDLE);
   assign out_busy             = (state_q != S_IDLE);
   assign out_div_enable       = (state_q == S_ISSUE);
   assign out_res_valid        = (state_q == S_RESULT);
   assign out_div_unsgn_or_sgn = op_q[0];
   assign out_div_num          = a_q;
   assign out_div_denom        = b_q;
   assign out_res_data         = res_data_q;
   assign out_res_dest         = dest_q;
   assign out_res_div_by_zero  = res_dbz_q;

endmodule

// File: doc/divide_issue_ctrl.md
# divide_issue_ctrl

- Sits between the CPU execute stage and the multi-cycle divider (`NonRestoringDivider`/`LongDivider`).
- Takes divide/modulo requests from execute and drives the divider's command handshake.
- Watches for completion, selects quotient or remainder, and hands one buffered result to writeback over a valid/ready link.
- Handles divide-by-zero without invoking the divider, and handles pipeline flushes while a division is in flight.

## Interface
Parameters:
- ARGS_WIDTH, 32, operand/result width; must match divider.
- REG_INDEX_WIDTH, 4, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_req_valid  in  1  execute presents a request.
- out_req_ready  out  1  request accepted on edge where valid&ready.
- in_op  in  2  bit0: 1=signed; bit1: 1=remainder, 0=quotient.
- in_a, in_b  in  ARGS_WIDTH  dividend, divisor.
- in_dest  in  REG_INDEX_WIDTH  destination register.
- in_flush  in  1  discard current operation.
- out_div_enable  out  1  to divider in_enable.
- out_div_unsgn_or_sgn  out  1  to divider; 1=signed.
- out_div_num, out_div_denom  out  ARGS_WIDTH  to divider operands.
- in_div_quot, in_div_rem  in  ARGS_WIDTH  divider results.
- in_div_can_accept_cmd, in_div_data_ready  in  1  divider status.
- out_res_valid  out  1  result available.
- in_res_ready  in  1  writeback accepts result.
- out_res_data  out  ARGS_WIDTH  selected result.
- out_res_dest  out  REG_INDEX_WIDTH  latched in_dest.
- out_res_div_by_zero  out  1  result came from divide-by-zero path.
- out_busy  out  1  state != IDLE; used as pipeline stall.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, DRAIN, RESULT.
- IDLE:
  - out_req_ready=1.
  - On valid&ready, latch op, a, b, dest.
  - b==0 → RESULT with data = (op[1] ? a : all-ones) and div_by_zero=1.
  - Otherwise → ISSUE.
- ISSUE:
  - out_div_enable=1; num/denom/unsgn_or_sgn driven from latches.
  - Command is taken on the edge where enable & in_div_can_accept_cmd; → WAIT_DONE.
  - If the divider is busy, enable holds and operands stay stable.
- WAIT_DONE:
  - Completion is the cycle where in_div_can_accept_cmd & in_div_data_ready.
  - On completion, capture (op[1] ? in_div_rem : in_div_quot) → RESULT.
  - The first WAIT_DONE cycle never sees a false completion, because the divider clears both flags on acceptance.
- RESULT:
  - out_res_valid=1; data/dest/flag stable until valid&in_res_ready → IDLE.
  - No new request is accepted in RESULT.
- DRAIN:
  - Waits for divider completion, discards the result → IDLE.
  - out_busy stays 1.
- Flush (highest priority):
  - IDLE: incoming request ignored.
  - ISSUE: if acceptance happens on the same edge → DRAIN; else → IDLE.
  - WAIT_DONE: → DRAIN.
  - DRAIN: stays DRAIN.
  - RESULT: → IDLE, result dropped.
- Signed overflow (MIN / -1) is passed through from the divider unmodified: quotient MIN, remainder 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State=IDLE; out_req_ready=1.
  - All other outputs are 0, including out_div_enable, out_res_valid, out_res_data, out_res_dest, out_res_div_by_zero and out_busy.
- Reset while the divider is busy is legal:
  - The divider has no reset, so the next ISSUE waits until in_div_can_accept_cmd=1.
  - The stale data_ready is consumed by that acceptance.
- Latency, request edge E with divisor nonzero:
  - Enable is high in cycle E+1.
  - If the divider is idle, acceptance happens at end of E+1.
  - out_res_valid is asserted the cycle after the completion cycle.
- Divide-by-zero: out_res_valid high in cycle E+1; out_div_enable never asserted.
- out_div_enable is asserted for exactly one accepted command per non-zero request; never asserted in IDLE, WAIT_DONE, DRAIN or RESULT.
- Outputs are registered-state decodes; no combinational path from in_res_ready or in_req_valid to any output.

## Test plan
- **Unsigned quotient:** divu (op=0) a=100, b=7, dest=5 → one enable pulse, result 14, dest 5, flag 0.
- **Signed operations:**
  - divs (op=1) a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD.
  - mods (op=3) same operands → 0xFFFFFFFF.
  - divs 0x80000000 / 0xFFFFFFFF → 0x80000000.
- **Divide-by-zero:**
  - divu 9/0 → 0xFFFFFFFF, flag 1, valid in E+1, enable never high.
  - mods 5/0 → 5.
- **Divider busy at issue:** hold in_div_can_accept_cmd=0 for 10 cycles → enable continuously high, num/denom stable, exactly one acceptance, correct result.
- **Flush in WAIT_DONE:** → no out_res_valid, out_busy=1 until divider completion. A subsequent divu 50/5 is not issued before then and returns 10.
- **Backpressure and mid-op reset:**
  - in_res_ready=0 for 5 cycles → data, dest and valid stable; out_req_ready=0.
  - rst_n low during WAIT_DONE → all outputs at reset values immediately; next request completes correctly.
